countdown_hms: RTL and testbench
================================

Name: countdown_hms

Overview:
- Hours/minutes/seconds countdown engine that sits directly downstream of the clock-setting front end.
- Accepts the operator-set H/M/S value, counts it down once per second, and returns the remaining time to the front end, which displays it.
- Provides run/pause control and raises completion flags at 00:00:00.

Parameters:
- TICKS_PER_SEC, 100_000_000: clock cycles per one-second decrement; must be >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- load  input  1  single-cycle pulse; capture hora_in/min_in/sec_in
- hora_in  input  7  set hours, 0..23
- min_in  input  7  set minutes, 0..59
- sec_in  input  7  set seconds, 0..59
- start  input  1  single-cycle pulse (already edge-detected); run/pause/acknowledge
- hora_left  output  7  remaining hours
- min_left  output  7  remaining minutes
- sec_left  output  7  remaining seconds
- running  output  1  high while in RUN
- done  output  1  level; high while in DONE
- done_pulse  output  1  one-cycle pulse on entry to DONE
- sec_tick  output  1  one-cycle pulse on each prescaler terminal count while in RUN

Behaviour:
- Reset values:
  - state IDLE
  - all *_left = 0
  - running = 0, done = 0, done_pulse = 0, sec_tick = 0
  - prescaler = 0
- All outputs are registered and change on the rising clock edge after their cause.
- Load clamping: hora_in > 23 loads 23; min_in or sec_in > 59 loads 59.
- State IDLE:
  - load: copy clamped inputs; stay in IDLE.
  - start, remaining time nonzero: go to RUN; prescaler cleared.
  - start, remaining time 00:00:00: ignored; stay in IDLE.
- State RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1. At terminal count it wraps to 0, sec_tick pulses, and one decrement is applied.
  - Decrement rules:
    - sec > 0: sec-1.
    - else min > 0: min-1, sec = 59.
    - else: hora-1, min = 59, sec = 59.
  - If the decrement produces 00:00:00, state becomes DONE on the same edge, with done = 1 and done_pulse = 1 for one cycle.
  - start: go to PAUSE; prescaler holds its value; no decrement on that edge.
  - load is ignored in RUN.
  - start coinciding with terminal count: the pause wins; the decrement is not applied and the prescaler holds.
- State PAUSE:
  - Counters frozen.
  - start: return to RUN; prescaler resumes from its held value.
  - load: copy clamped inputs, clear prescaler, go to IDLE.
- State DONE:
  - *_left stay at 0; done = 1.
  - start: go to IDLE; done clears.
  - load: copy inputs, go to IDLE; done clears.
- Simultaneous load and start in IDLE, PAUSE or DONE: load has priority; start is discarded that cycle.
- Asynchronous reset mid-count: immediate return to reset values; no done_pulse is produced.
- Arithmetic: 7-bit unsigned. Counters never wrap below 0 or exceed their clamp limits.

Decomposition:
- Shared package:
  - State enumeration: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3.
  - Constants MAX_HORA = 23 and MAX_MS = 59.
  - Clamp function.
- Sub-module hms_tick_gen: prescaler with enable, hold and clear inputs and a terminal-count output.
- The FSM and the borrow chain stay in countdown_hms.

Test Plan (TICKS_PER_SEC = 4 in simulation):
- Reset, then load 00:00:03, then start -> running = 1 on the next edge; sec_left steps 3, 2, 1, 0 at 4-cycle intervals; done_pulse high for exactly one cycle together with sec_left = 0; state DONE, running = 0.
- Load 01:00:00, then run one tick -> 00:59:59; load 00:01:00, then run one tick -> 00:00:59.
- Load hora_in = 30, min_in = 75, sec_in = 60 -> outputs read 23:59:59.
- Running 00:00:10: start after 2 prescaler cycles -> PAUSE, counters frozen for 20 cycles; start again -> the first decrement arrives 2 cycles later (prescaler resumed); load during RUN has no effect.
- In IDLE with 00:00:00, start -> stays IDLE, running = 0; in DONE, load 00:00:05 and start in the same cycle -> IDLE holding 00:00:05, done = 0, running = 0.
- Assert reset mid-count at 00:00:02 -> all outputs 0 immediately; no done_pulse either during or after reset.

Source files
------------

// File: rtl/countdown_hms_pkg.sv
// Shared types, limits and helpers for the H/M/S countdown engine.
package countdown_hms_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

    localparam logic [6:0] MAX_HORA = 7'd23;
    localparam logic [6:0] MAX_MS   = 7'd59;

    // Saturate an operator-entered field to its legal maximum.
    function automatic logic [6:0] clamp(input logic [6:0] value, input logic [6:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/hms_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled and not held.
module hms_tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic hold,
    input  logic clear,
    output logic terminal
);

    localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_reg;

    // A held prescaler never reports terminal, so a pause on the wrap edge suppresses the tick.
    assign terminal = enable && !hold && (count_reg == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !hold) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_hms.sv
// Countdown engine: load/run/pause/done control and the H:M:S borrow chain.
module countdown_hms
    import countdown_hms_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] hora_in,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    input  logic       start,
    output logic [6:0] hora_left,
    output logic [6:0] min_left,
    output logic [6:0] sec_left,
    output logic       running,
    output logic       done,
    output logic       done_pulse,
    output logic       sec_tick
);

    cd_state_t  state_reg, state_next;
    logic [6:0] hora_reg, hora_next;
    logic [6:0] min_reg, min_next;
    logic [6:0] sec_reg, sec_next;
    logic       running_reg, running_next;
    logic       done_reg, done_next;
    logic       pulse_reg, pulse_next;
    logic       tick_reg, tick_next;

    logic       terminal;
    logic       pre_clear;
    logic [6:0] hora_load, min_load, sec_load;
    logic [6:0] dec_hora, dec_min, dec_sec;
    logic       time_zero, dec_zero;

    assign pre_clear = (state_reg == IDLE) || (state_reg == DONE) ||
                       ((state_reg == PAUSE) && load);

    hms_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (state_reg == RUN),
        .hold     (start),
        .clear    (pre_clear),
        .terminal (terminal)
    );

    assign hora_load = clamp(hora_in, MAX_HORA);
    assign min_load  = clamp(min_in, MAX_MS);
    assign sec_load  = clamp(sec_in, MAX_MS);

    assign time_zero = (hora_reg == 7'd0) && (min_reg == 7'd0) && (sec_reg == 7'd0);

    // Borrow chain; the all-zero case holds at zero rather than wrapping.
    always_comb begin
        dec_hora = hora_reg;
        dec_min  = min_reg;
        dec_sec  = sec_reg;
        if (sec_reg != 7'd0) begin
            dec_sec = sec_reg - 7'd1;
        end else if (min_reg != 7'd0) begin
            dec_min = min_reg - 7'd1;
            dec_sec = MAX_MS;
        end else if (hora_reg != 7'd0) begin
            dec_hora = hora_reg - 7'd1;
            dec_min  = MAX_MS;
            dec_sec  = MAX_MS;
        end
    end

    assign dec_zero = (dec_hora == 7'd0) && (dec_min == 7'd0) && (dec_sec == 7'd0);

    always_comb begin
        state_next = state_reg;
        hora_next  = hora_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;
        pulse_next = 1'b0;
        tick_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    hora_next = hora_load;
                    min_next  = min_load;
                    sec_next  = sec_load;
                end else if (start && !time_zero) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    state_next = PAUSE;
                end else if (terminal) begin
                    tick_next = 1'b1;
                    hora_next = dec_hora;
                    min_next  = dec_min;
                    sec_next  = dec_sec;
                    if (dec_zero) begin
                        state_next = DONE;
                        pulse_next = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    hora_next  = hora_load;
                    min_next   = min_load;
                    sec_next   = sec_load;
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    hora_next  = hora_load;
                    min_next   = min_load;
                    sec_next   = sec_load;
                    state_next = IDLE;
                end else if (start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        running_next = (state_next == RUN);
        done_next    = (state_next == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            hora_reg    <= 7'd0;
            min_reg     <= 7'd0;
            sec_reg     <= 7'd0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            pulse_reg   <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hora_reg    <= hora_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            running_reg <= running_next;
            done_reg    <= done_next;
            pulse_reg   <= pulse_next;
            tick_reg    <= tick_next;
        end
    end

    assign hora_left  = hora_reg;
    assign min_left   = min_reg;
    assign sec_left   = sec_reg;
    assign running    = running_reg;
    assign done       = done_reg;
    assign done_pulse = pulse_reg;
    assign sec_tick   = tick_reg;

endmodule

// File: tb/tb_countdown_hms.sv
// Bench for countdown_hms: total-seconds reference model checked every cycle plus directed literals.
module tb_countdown_hms;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic [6:0] hora_in = 7'd0;
    logic [6:0] min_in = 7'd0;
    logic [6:0] sec_in = 7'd0;
    logic [6:0] hora_left, min_left, sec_left;
    logic       running, done, done_pulse, sec_tick;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_count = 0;

    // Model state: 0 idle, 1 run, 2 pause, 3 done; time kept as total seconds.
    int m_state = 0;
    int m_total = 0;
    int m_pre = 0;
    bit m_pulse = 1'b0;
    bit m_tick = 1'b0;

    countdown_hms #(.TICKS_PER_SEC(T)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .hora_in    (hora_in),
        .min_in     (min_in),
        .sec_in     (sec_in),
        .start      (start),
        .hora_left  (hora_left),
        .min_left   (min_left),
        .sec_left   (sec_left),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse),
        .sec_tick   (sec_tick)
    );

    always #5 clock = ~clock;

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clock or posedge reset) begin : model
        int st, tot, pre, lv;
        bit pul, tk;
        if (reset) begin
            m_state <= 0;
            m_total <= 0;
            m_pre   <= 0;
            m_pulse <= 1'b0;
            m_tick  <= 1'b0;
        end else begin
            st  = m_state;
            tot = m_total;
            pre = m_pre;
            pul = 1'b0;
            tk  = 1'b0;
            lv  = lim(int'(hora_in), 23) * 3600 + lim(int'(min_in), 59) * 60 + lim(int'(sec_in), 59);
            case (st)
                0: begin
                    if (load) tot = lv;
                    else if (start && tot != 0) begin st = 1; pre = 0; end
                end
                1: begin
                    if (start) st = 2;
                    else if (pre == T - 1) begin
                        pre = 0;
                        tk  = 1'b1;
                        tot = tot - 1;
                        if (tot == 0) begin st = 3; pul = 1'b1; end
                    end else pre = pre + 1;
                end
                2: begin
                    if (load) begin tot = lv; pre = 0; st = 0; end
                    else if (start) st = 1;
                end
                default: begin
                    if (load) begin tot = lv; st = 0; end
                    else if (start) st = 0;
                end
            endcase
            m_state <= st;
            m_total <= tot;
            m_pre   <= pre;
            m_pulse <= pul;
            m_tick  <= tk;
        end
    end

    always @(negedge clock) begin
        check("hora_left", int'(hora_left), m_total / 3600);
        check("min_left", int'(min_left), (m_total / 60) % 60);
        check("sec_left", int'(sec_left), m_total % 60);
        check("running", int'(running), int'(m_state == 1));
        check("done", int'(done), int'(m_state == 3));
        check("done_pulse", int'(done_pulse), int'(m_pulse));
        check("sec_tick", int'(sec_tick), int'(m_tick));
        if (done_pulse) pulse_count++;
    end

    // Apply one cycle of inputs starting just after a falling edge.
    task automatic step(input bit ld, input bit st, input int h, input int m, input int s);
        load    = ld;
        start   = st;
        hora_in = 7'(h);
        min_in  = 7'(m);
        sec_in  = 7'(s);
        @(negedge clock);
        load  = 1'b0;
        start = 1'b0;
        $display("t=%0t load=%0b start=%0b in=%0d:%0d:%0d -> left=%0d:%0d:%0d run=%0b done=%0b",
                 $time, ld, st, h, m, s, hora_left, min_left, sec_left, running, done);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_hms(input string name, input int h, input int m, input int s);
        check({name, "_h"}, int'(hora_left), h);
        check({name, "_m"}, int'(min_left), m);
        check({name, "_s"}, int'(sec_left), s);
    endtask

    initial begin
        int n;
        int pulses_before;

        wait_cycles(3);
        reset = 1'b0;
        check_hms("reset", 0, 0, 0);
        check("reset_running", int'(running), 0);
        check("reset_done", int'(done), 0);

        // 00:00:03 run to completion
        step(1'b1, 1'b0, 0, 0, 3);
        check_hms("load3", 0, 0, 3);
        step(1'b0, 1'b1, 0, 0, 0);
        check("run_after_start", int'(running), 1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("done_latency", n, 12);
        check("done_pulse_at_done", int'(done_pulse), 1);
        check("sec_at_done", int'(sec_left), 0);
        wait_cycles(1);
        check("done_pulse_one_cycle", int'(done_pulse), 0);
        check("done_level", int'(done), 1);
        check("running_in_done", int'(running), 0);
        check("pulse_count", pulse_count, 1);

        // DONE: load and start together -> IDLE with new value
        step(1'b1, 1'b1, 0, 0, 5);
        check_hms("done_load", 0, 0, 5);
        check("done_cleared", int'(done), 0);
        check("idle_not_running", int'(running), 0);
        wait_cycles(2);
        check("start_discarded", int'(running), 0);

        // start on 00:00:00 in IDLE ignored
        step(1'b1, 1'b0, 0, 0, 0);
        step(1'b0, 1'b1, 0, 0, 0);
        wait_cycles(1);
        check("zero_start_ignored", int'(running), 0);

        // borrow from hours
        step(1'b1, 1'b0, 1, 0, 0);
        step(1'b0, 1'b1, 0, 0, 0);
        wait_cycles(4);
        check_hms("borrow_h", 0, 59, 59);
        step(1'b0, 1'b1, 0, 0, 0);
        step(1'b1, 1'b0, 0, 1, 0);
        step(1'b0, 1'b1, 0, 0, 0);
        wait_cycles(4);
        check_hms("borrow_m", 0, 0, 59);
        step(1'b0, 1'b1, 0, 0, 0);

        // clamping
        step(1'b1, 1'b0, 30, 75, 60);
        check_hms("clamp", 23, 59, 59);
        step(1'b1, 1'b0, 127, 127, 127);
        check_hms("clamp_max", 23, 59, 59);
        step(1'b1, 1'b0, 23, 58, 0);
        check_hms("no_clamp", 23, 58, 0);

        // pause/resume with held prescaler
        step(1'b1, 1'b0, 0, 0, 10);
        step(1'b0, 1'b1, 0, 0, 0);
        wait_cycles(2);
        step(1'b0, 1'b1, 0, 0, 0);
        check("paused", int'(running), 0);
        wait_cycles(20);
        check("frozen_sec", int'(sec_left), 10);
        step(1'b0, 1'b1, 0, 0, 0);
        check("resumed", int'(running), 1);
        wait_cycles(1);
        check("resume_before_tick", int'(sec_left), 10);
        wait_cycles(1);
        check("resume_tick", int'(sec_left), 9);
        step(1'b1, 1'b0, 0, 0, 50);
        check("load_in_run_ignored", int'(sec_left), 9);
        check("still_running", int'(running), 1);

        // asynchronous reset mid-count
        step(1'b0, 1'b1, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 2);
        step(1'b0, 1'b1, 0, 0, 0);
        wait_cycles(2);
        check("pre_reset_sec", int'(sec_left), 2);
        pulses_before = pulse_count;
        #1 reset = 1'b1;
        #1;
        check_hms("async_reset", 0, 0, 0);
        check("async_reset_running", int'(running), 0);
        check("async_reset_done", int'(done), 0);
        check("async_reset_pulse", int'(done_pulse), 0);
        check("async_reset_tick", int'(sec_tick), 0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(15);
        check("no_pulse_after_reset", pulse_count, pulses_before);
        check("idle_after_reset", int'(running), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
